// File: rtl/spi_acl_pkg.sv
// Shared opcodes, register addresses and FSM encoding for the SPI accelerometer stand-in.
package spi_acl_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h0A;
  localparam logic [7:0] OP_REG_READ  = 8'h0B;
  localparam logic [7:0] OP_FIFO_READ = 8'h0D;

  localparam logic [7:0] XDATA = 8'h08;
  localparam logic [7:0] YDATA = 8'h09;
  localparam logic [7:0] ZDATA = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StRdata,
    StFdata,
    StIgnore
  } spi_state_e;

  function automatic logic is_reg_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_REG_READ);
  endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO; push is dropped when full, pop is ignored when empty.
module sync_fifo_byte #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_acl_target.sv
// SPI Mode-0 target emulating the accelerometer register/FIFO command set, oversampled on clk.
module spi_acl_target
  import spi_acl_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 64,
  parameter logic [7:0]  RO_LIMIT   = 8'h1F,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          cs,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic                          host_we,
  input  logic [5:0]                    host_addr,
  input  logic [7:0]                    host_wdata,
  input  logic                          fifo_push,
  input  logic [7:0]                    fifo_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          spi_wr_valid,
  output logic [5:0]                    spi_wr_addr,
  output logic [7:0]                    spi_wr_data
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  // Synchronizers reset low so a CS already held low after reset never looks like a fall.
  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] && !sclk_prev;
  assign sclk_fall = !sclk_sync[1] && sclk_prev;
  assign cs_fall   = !cs_sync[1] && cs_prev;
  assign cs_rise   = cs_sync[1] && !cs_prev;

  spi_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          is_write_q;
  logic [AW-1:0] addr_q, addr_inc;
  logic [7:0]    tx_q;
  logic [7:0]    regs_q [REG_COUNT];

  logic [7:0] rx_byte, fifo_rdata, fifo_head;
  logic       byte_done, reg_we, fifo_pop, fifo_empty;

  assign rx_byte   = {shift_q[6:0], mosi_sync[1]};
  assign addr_inc  = addr_q + 1'b1;
  assign fifo_head = fifo_empty ? 8'h00 : fifo_rdata;

  always_comb begin
    byte_done = sclk_rise && !cs_rise && (bit_cnt_q == 3'd7) &&
                (state_q != StIdle) && (state_q != StIgnore);
    reg_we    = byte_done && (state_q == StWdata) && (8'(addr_q) >= RO_LIMIT);
    fifo_pop  = byte_done && ((state_q == StFdata) ||
                              ((state_q == StCmd) && (rx_byte == OP_FIFO_READ)));
  end

  // SPI write is applied after the host write so it wins on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= 8'h00;
    end else begin
      if (host_we) regs_q[host_addr[AW-1:0]] <= host_wdata;
      if (reg_we)  regs_q[addr_q] <= rx_byte;
    end
  end

  sync_fifo_byte #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      tx_q         <= '0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      spi_wr_valid <= 1'b0;
      spi_wr_addr  <= '0;
      spi_wr_data  <= '0;
    end else begin
      spi_wr_valid <= 1'b0;
      if (cs_rise) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        tx_q      <= '0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else if (state_q == StIdle) begin
        if (cs_fall) begin
          state_q   <= StCmd;
          bit_cnt_q <= '0;
          tx_q      <= '0;
          miso      <= 1'b0;
          miso_oe   <= 1'b1;
        end
      end else begin
        if (sclk_rise && (state_q != StIgnore)) begin
          shift_q   <= rx_byte;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (byte_done) begin
          unique case (state_q)
            StCmd: begin
              if (is_reg_op(rx_byte)) begin
                is_write_q <= (rx_byte == OP_WRITE);
                state_q    <= StAddr;
              end else if (rx_byte == OP_FIFO_READ) begin
                state_q <= StFdata;
                tx_q    <= fifo_head;
              end else begin
                state_q <= StIgnore;
              end
            end
            StAddr: begin
              addr_q <= rx_byte[AW-1:0];
              if (is_write_q) begin
                state_q <= StWdata;
              end else begin
                state_q <= StRdata;
                tx_q    <= regs_q[rx_byte[AW-1:0]];
              end
            end
            StWdata: begin
              spi_wr_valid <= 1'b1;
              spi_wr_addr  <= 6'(addr_q);
              spi_wr_data  <= rx_byte;
              addr_q       <= addr_inc;
            end
            StRdata: begin
              addr_q <= addr_inc;
              tx_q   <= regs_q[addr_inc];
            end
            StFdata: tx_q <= fifo_head;
            default: ;
          endcase
        end
        if (sclk_fall) begin
          if ((state_q == StRdata) || (state_q == StFdata)) begin
            miso <= tx_q[7];
            tx_q <= {tx_q[6:0], 1'b0};
          end else begin
            miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_acl_target.sv
// Directed bench: bit-banged Mode-0 master against spi_acl_target with hand-computed expectations.
module tb_spi_acl_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe;
  logic       host_we = 1'b0;
  logic [5:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       fifo_push = 1'b0;
  logic [7:0] fifo_data = '0;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       spi_wr_valid;
  logic [5:0] spi_wr_addr;
  logic [7:0] spi_wr_data;

  int total = 0;
  int bad   = 0;

  int         wr_cnt = 0;
  logic [5:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  int         miso_ones = 0;
  int         oe_low_in_txn = 0;
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  spi_acl_target dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .fifo_push    (fifo_push),
    .fifo_data    (fifo_data),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .spi_wr_valid (spi_wr_valid),
    .spi_wr_addr  (spi_wr_addr),
    .spi_wr_data  (spi_wr_data)
  );

  always @(negedge clk) begin
    if (spi_wr_valid) begin
      wr_cnt++;
      last_wr_addr = spi_wr_addr;
      last_wr_data = spi_wr_data;
    end
    if (mon_en && miso === 1'b1) miso_ones++;
    if (mon_en && miso_oe !== 1'b1) oe_low_in_txn++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Half SCLK period of 8 clk keeps SCLK at CLK/16; master samples MISO at its rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      wait_clk(8);
      sclk = 1'b1;
      rx[i] = miso;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_start();
    cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(8);
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    fifo_push = 1'b1; fifo_data = d;
    @(negedge clk);
    fifo_push = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] junk;
    cs_start();
    spi_byte(8'h0B, junk);
    spi_byte(a, junk);
    spi_byte(8'h00, d);
    cs_end();
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] junk;
    cs_start();
    spi_byte(8'h0A, junk);
    spi_byte(a, junk);
    spi_byte(d, junk);
    cs_end();
  endtask

  initial begin
    logic [7:0] rx, rx2, junk;
    int wr_before;

    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_wr_valid", 32'(spi_wr_valid), 32'd0);
    check("rst_wr_addr", 32'(spi_wr_addr), 32'd0);
    check("rst_wr_data", 32'(spi_wr_data), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Single register read with MISO_OE tracked across the transaction
    host_write(6'h08, 8'hA5);
    wr_before = wr_cnt;
    cs_start();
    mon_en = 1'b1;
    spi_byte(8'h0B, junk);
    spi_byte(8'h08, junk);
    spi_byte(8'h00, rx);
    mon_en = 1'b0;
    cs_end();
    check("read_08", 32'(rx), 32'hA5);
    check("read_oe_held", 32'(oe_low_in_txn), 32'd0);
    check("read_no_wr_valid", 32'(wr_cnt - wr_before), 32'd0);
    check("read_oe_after", 32'(miso_oe), 32'd0);
    check("read_miso_after", 32'(miso), 32'd0);

    // Burst read wrapping 0x3F -> 0x00
    host_write(6'h3F, 8'h11);
    host_write(6'h00, 8'h22);
    cs_start();
    spi_byte(8'h0B, junk);
    spi_byte(8'h3F, junk);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    cs_end();
    check("burst_3f", 32'(rx), 32'h11);
    check("burst_wrap_00", 32'(rx2), 32'h22);

    // Writable and protected writes
    wr_before = wr_cnt;
    reg_write(8'h20, 8'h5C);
    check("wr20_pulses", 32'(wr_cnt - wr_before), 32'd1);
    check("wr20_addr", 32'(last_wr_addr), 32'h20);
    check("wr20_data", 32'(last_wr_data), 32'h5C);
    reg_read(8'h20, rx);
    check("wr20_readback", 32'(rx), 32'h5C);
    wr_before = wr_cnt;
    reg_write(8'h08, 8'h77);
    check("wr08_pulses", 32'(wr_cnt - wr_before), 32'd1);
    check("wr08_addr", 32'(last_wr_addr), 32'h08);
    check("wr08_data", 32'(last_wr_data), 32'h77);
    reg_read(8'h08, rx);
    check("wr08_protected", 32'(rx), 32'hA5);

    // FIFO read, including an empty-FIFO byte
    push(8'h01);
    push(8'h02);
    check("fifo_count_2", 32'(fifo_count), 32'd2);
    cs_start();
    spi_byte(8'h0D, junk);
    check("fifo_count_after_cmd", 32'(fifo_count), 32'd1);
    spi_byte(8'h00, rx);
    check("fifo_b0", 32'(rx), 32'h01);
    spi_byte(8'h00, rx);
    check("fifo_b1", 32'(rx), 32'h02);
    spi_byte(8'h00, rx);
    check("fifo_b2_empty", 32'(rx), 32'h00);
    cs_end();
    check("fifo_count_0", 32'(fifo_count), 32'd0);

    // Fill to full, drop the 17th push, then drain all
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    check("fifo_full", 32'(fifo_full), 32'd1);
    check("fifo_count_16", 32'(fifo_count), 32'd16);
    push(8'hEE);
    check("fifo_drop_count", 32'(fifo_count), 32'd16);
    cs_start();
    spi_byte(8'h0D, junk);
    for (int i = 0; i < 16; i++) begin
      spi_byte(8'h00, rx);
      check($sformatf("fifo_drain_%0d", i), 32'(rx), 32'h30 + 32'(i));
    end
    spi_byte(8'h00, rx);
    check("fifo_drain_end", 32'(rx), 32'h00);
    cs_end();
    check("fifo_not_full", 32'(fifo_full), 32'd0);

    // Partial write byte is discarded
    host_write(6'h21, 8'h44);
    wr_before = wr_cnt;
    cs_start();
    spi_byte(8'h0A, junk);
    spi_byte(8'h21, junk);
    spi_bits(8'hFF, 4, junk);
    cs_end();
    check("abort_no_pulse", 32'(wr_cnt - wr_before), 32'd0);
    reg_read(8'h21, rx);
    check("abort_unchanged", 32'(rx), 32'h44);

    // Unknown command keeps MISO low
    miso_ones = 0;
    cs_start();
    mon_en = 1'b1;
    spi_byte(8'hFF, junk);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    mon_en = 1'b0;
    cs_end();
    check("ignore_miso_ones", 32'(miso_ones), 32'd0);
    check("ignore_rx", 32'({rx, rx2}), 32'h0000);

    // Reset mid-burst, then ensure a held-low CS is ignored
    push(8'h55);
    host_write(6'h09, 8'hFF);
    cs_start();
    spi_byte(8'h0B, junk);
    spi_byte(8'h08, junk);
    spi_bits(8'h00, 4, junk);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_oe", 32'(miso_oe), 32'd0);
    check("midrst_wr_valid", 32'(spi_wr_valid), 32'd0);
    check("midrst_wr_addr", 32'(spi_wr_addr), 32'd0);
    check("midrst_wr_data", 32'(spi_wr_data), 32'd0);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_fifo_full", 32'(fifo_full), 32'd0);
    rst = 1'b0;
    wait_clk(8);
    spi_byte(8'h0B, junk);
    spi_byte(8'h09, junk);
    check("held_cs_oe", 32'(miso_oe), 32'd0);
    cs_end();
    reg_read(8'h08, rx);
    check("postrst_reg08", 32'(rx), 32'h00);
    reg_read(8'h09, rx);
    check("postrst_reg09", 32'(rx), 32'h00);
    wr_before = wr_cnt;
    reg_write(8'h22, 8'h33);
    check("postrst_wr_pulse", 32'(wr_cnt - wr_before), 32'd1);
    reg_read(8'h22, rx);
    check("postrst_readback", 32'(rx), 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
